// File: rtl/gtfwizard_raw_gtwiz_buffbypass_rx_mc_if.sv
// Handshake bundle between the RX buffer-bypass controller and the GT channels / DRP sequencer.
// The controller uses the master modport; the GT / DRP side uses slave.
interface gtfwizard_raw_gtwiz_buffbypass_rx_mc_if #(
    parameter int N = 4
);
    logic         gtwiz_buffbypass_rx_start_in;
    logic         workaround_bypass_in;
    logic         drp_reconfig_done_in;
    logic [N-1:0] dmon_bad_align_in;
    logic [N-1:0] rxdlysresetdone_in;
    logic [N-1:0] rxphaligndone_in;
    logic [N-1:0] rxsyncdone_in;

    logic [N-1:0] rxdlysreset_out;
    logic [N-1:0] rxphalign_out;
    logic [N-1:0] rxphalignen_out;
    logic         drp_reconfig_rdy_out;
    logic         drp_switch_am_out;
    logic         done_out;
    logic         error_out;
    logic [3:0]   retry_count_out;
    logic [3:0]   sm_state_out;

    modport master (
        input  gtwiz_buffbypass_rx_start_in, workaround_bypass_in, drp_reconfig_done_in,
               dmon_bad_align_in, rxdlysresetdone_in, rxphaligndone_in, rxsyncdone_in,
        output rxdlysreset_out, rxphalign_out, rxphalignen_out, drp_reconfig_rdy_out,
               drp_switch_am_out, done_out, error_out, retry_count_out, sm_state_out
    );

    modport slave (
        output gtwiz_buffbypass_rx_start_in, workaround_bypass_in, drp_reconfig_done_in,
               dmon_bad_align_in, rxdlysresetdone_in, rxphaligndone_in, rxsyncdone_in,
        input  rxdlysreset_out, rxphalign_out, rxphalignen_out, drp_reconfig_rdy_out,
               drp_switch_am_out, done_out, error_out, retry_count_out, sm_state_out
    );
endinterface

// File: rtl/gtfwizard_raw_gtwiz_buffbypass_rx_mc.sv
// Multi-channel RX buffer-bypass alignment controller: manual-mode alignment with dmon-checked
// retries, falling back to auto-mode through a DRP reconfiguration, with per-state timeout.
module gtfwizard_raw_gtwiz_buffbypass_rx_mc #(
    parameter int P_TOTAL_NUMBER_OF_CHANNELS = 4,
    parameter int P_MASTER_CHANNEL_POINTER   = 0,
    parameter int P_MAX_MM_RETRIES           = 3,
    parameter int P_TIMEOUT_CYCLES           = 65535
) (
    input logic gtwiz_buffbypass_rx_clk_in,
    input logic gtwiz_buffbypass_rx_reset_in,
    gtfwizard_raw_gtwiz_buffbypass_rx_mc_if.master bus
);
    localparam int N = P_TOTAL_NUMBER_OF_CHANNELS;

    localparam logic [3:0] ST_IDLE          = 4'd0;
    localparam logic [3:0] ST_MM_WAIT_DRP   = 4'd1;
    localparam logic [3:0] ST_MM_WAIT_DLYS  = 4'd2;
    localparam logic [3:0] ST_MM_WAIT_PHAL  = 4'd3;
    localparam logic [3:0] ST_MM_POLL_DMON  = 4'd4;
    localparam logic [3:0] ST_AM_WAIT_DRP   = 4'd5;
    localparam logic [3:0] ST_AM_WAIT_SYNC  = 4'd6;
    localparam logic [3:0] ST_DONE          = 4'd7;
    localparam logic [3:0] ST_ERROR         = 4'd8;

    localparam logic [3:0]  MAX_RETRY = 4'(P_MAX_MM_RETRIES);
    localparam logic [15:0] TO_LAST   = 16'(P_TIMEOUT_CYCLES - 1);

    logic [3:0]   state_q, state_d;
    logic [15:0]  to_q, to_d;
    logic         drp_q, sync_q;
    logic         rdy_q, rdy_d;
    logic         am_q, am_d;
    logic [N-1:0] dlys_q, dlys_d;
    logic [N-1:0] phal_q, phal_d;
    logic [N-1:0] phalen_q, phalen_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [3:0]   retry_q, retry_d;

    logic         drp_edge, sync_edge, timed, to_hit, fail;
    logic [N-1:0] dlys_left, phal_left;
    logic [3:0]   retry_inc;

    always_comb begin
        drp_edge  = bus.drp_reconfig_done_in & ~drp_q;
        sync_edge = bus.rxsyncdone_in[P_MASTER_CHANNEL_POINTER] & ~sync_q;
        timed     = (state_q == ST_MM_WAIT_DRP) || (state_q == ST_MM_WAIT_DLYS) ||
                    (state_q == ST_MM_WAIT_PHAL) || (state_q == ST_AM_WAIT_DRP) ||
                    (state_q == ST_AM_WAIT_SYNC);
        to_hit    = timed && (to_q == TO_LAST);
        dlys_left = dlys_q & ~bus.rxdlysresetdone_in;
        phal_left = phal_q & ~bus.rxphaligndone_in;
        retry_inc = (retry_q >= MAX_RETRY) ? retry_q : retry_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        am_d     = am_q;
        dlys_d   = dlys_q;
        phal_d   = phal_q;
        phalen_d = phalen_q;
        done_d   = done_q;
        err_d    = err_q;
        retry_d  = retry_q;
        fail     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.gtwiz_buffbypass_rx_start_in) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    dlys_d  = '0;
                    phal_d  = '0;
                    rdy_d   = 1'b1;
                    if (bus.workaround_bypass_in) begin
                        state_d  = ST_AM_WAIT_DRP;
                        am_d     = 1'b1;
                        phalen_d = '0;
                    end else begin
                        state_d  = ST_MM_WAIT_DRP;
                        am_d     = 1'b0;
                        phalen_d = '1;
                    end
                end
            end
            ST_MM_WAIT_DRP: begin
                // DRP edge takes priority over a coincident timeout
                if (drp_edge) begin
                    rdy_d   = 1'b0;
                    dlys_d  = '1;
                    state_d = ST_MM_WAIT_DLYS;
                end else if (to_hit) begin
                    fail = 1'b1;
                end
            end
            ST_MM_WAIT_DLYS: begin
                dlys_d = dlys_left;
                if (dlys_left == '0) begin
                    phal_d  = '1;
                    state_d = ST_MM_WAIT_PHAL;
                end else if (to_hit) begin
                    fail = 1'b1;
                end
            end
            ST_MM_WAIT_PHAL: begin
                phal_d = phal_left;
                if (phal_left == '0) begin
                    state_d = ST_MM_POLL_DMON;
                end else if (to_hit) begin
                    fail = 1'b1;
                end
            end
            ST_MM_POLL_DMON: begin
                if (bus.dmon_bad_align_in == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc < MAX_RETRY) begin
                        dlys_d  = '1;
                        state_d = ST_MM_WAIT_DLYS;
                    end else begin
                        phalen_d = '0;
                        phal_d   = '0;
                        am_d     = 1'b1;
                        rdy_d    = 1'b1;
                        state_d  = ST_AM_WAIT_DRP;
                    end
                end
            end
            ST_AM_WAIT_DRP: begin
                if (drp_edge) begin
                    rdy_d   = 1'b0;
                    dlys_d  = '1;
                    state_d = ST_AM_WAIT_SYNC;
                end else if (to_hit) begin
                    fail = 1'b1;
                end
            end
            ST_AM_WAIT_SYNC: begin
                dlys_d = '0;
                if (sync_edge) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (to_hit) begin
                    fail = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            state_d  = ST_ERROR;
            err_d    = 1'b1;
            done_d   = 1'b0;
            rdy_d    = 1'b0;
            dlys_d   = '0;
            phal_d   = '0;
            phalen_d = '0;
        end
    end

    always_comb begin
        to_d = (state_d != state_q || !timed) ? '0 : to_q + 16'd1;
    end

    always_ff @(posedge gtwiz_buffbypass_rx_clk_in or posedge gtwiz_buffbypass_rx_reset_in) begin
        if (gtwiz_buffbypass_rx_reset_in) begin
            state_q  <= ST_IDLE;
            to_q     <= '0;
            drp_q    <= 1'b0;
            sync_q   <= 1'b0;
            rdy_q    <= 1'b0;
            am_q     <= 1'b0;
            dlys_q   <= '0;
            phal_q   <= '0;
            phalen_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_q     <= to_d;
            drp_q    <= bus.drp_reconfig_done_in;
            sync_q   <= bus.rxsyncdone_in[P_MASTER_CHANNEL_POINTER];
            rdy_q    <= rdy_d;
            am_q     <= am_d;
            dlys_q   <= dlys_d;
            phal_q   <= phal_d;
            phalen_q <= phalen_d;
            done_q   <= done_d;
            err_q    <= err_d;
            retry_q  <= retry_d;
        end
    end

    assign bus.rxdlysreset_out      = dlys_q;
    assign bus.rxphalign_out        = phal_q;
    assign bus.rxphalignen_out      = phalen_q;
    assign bus.drp_reconfig_rdy_out = rdy_q;
    assign bus.drp_switch_am_out    = am_q;
    assign bus.done_out             = done_q;
    assign bus.error_out            = err_q;
    assign bus.retry_count_out      = retry_q;
    assign bus.sm_state_out         = state_q;
endmodule

// File: doc/gtfwizard_raw_gtwiz_buffbypass_rx_mc.md
GTFWIZARD_RAW_GTWIZ_BUFFBYPASS_RX_MC -- requirements
Module: gtfwizard_raw_gtwiz_buffbypass_rx_mc

Interface
REQ-001 SHALL have parameter P_TOTAL_NUMBER_OF_CHANNELS, default 4, channel count (1..16).
REQ-002 SHALL have parameter P_MASTER_CHANNEL_POINTER, default 0, master channel index (< channel count).
REQ-003 SHALL have parameter P_MAX_MM_RETRIES, default 3, manual-mode (MM) alignment attempts before auto-mode (AM) fallback (1..15).
REQ-004 SHALL have parameter P_TIMEOUT_CYCLES, default 65535, wait-state timeout in clocks (16-bit counter).
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-006 Ports, all non-clock inputs synchronous to clock (synchronised upstream); N = P_TOTAL_NUMBER_OF_CHANNELS:
- gtwiz_buffbypass_rx_clk_in  in  1  block clock
- gtwiz_buffbypass_rx_reset_in  in  1  async active-high reset
- gtwiz_buffbypass_rx_start_in  in  1  start pulse
- workaround_bypass_in  in  1  1 = skip MM, go straight to AM
- drp_reconfig_done_in  in  1  DRP reconfiguration complete (level)
- dmon_bad_align_in  in  N  per-channel bad-alignment flag
- rxdlysresetdone_in / rxphaligndone_in / rxsyncdone_in  in  N each  GT status
- rxdlysreset_out / rxphalign_out / rxphalignen_out  out  N each  GT controls
- drp_reconfig_rdy_out  out  1  request DRP reconfig; drp_switch_am_out  out  1  target mode (1 = AM)
- done_out / error_out  out  1 each  completion / failure
- retry_count_out  out  4  MM attempts consumed; sm_state_out  out  4  FSM state

Function
REQ-007 States: IDLE(0), MM_WAIT_DRP(1), MM_WAIT_DLYSRESETDONE(2), MM_WAIT_PHALIGNDONE(3), MM_POLL_DMON(4), AM_WAIT_DRP(5), AM_WAIT_SYNCDONE(6), DONE(7), ERROR(8).
REQ-008 Rising edge of drp_reconfig_done_in SHALL be detected with one internal register; only the edge advances DRP wait states.
REQ-009 IDLE + start_in: clear done/error/retry_count; workaround_bypass_in=1 -> AM_WAIT_DRP with drp_switch_am_out=1, else MM_WAIT_DRP with drp_switch_am_out=0, rxphalignen_out all 1.
REQ-010 MM_WAIT_DRP: drp_reconfig_rdy_out=1; on DRP edge drop it, assert all rxdlysreset_out, -> MM_WAIT_DLYSRESETDONE.
REQ-011 MM_WAIT_DLYSRESETDONE: rxdlysreset_out held per channel until that channel's rxdlysresetdone_in=1 (per-channel deassert, registered); when AND of all N seen done -> assert all rxphalign_out, -> MM_WAIT_PHALIGNDONE.
REQ-012 MM_WAIT_PHALIGNDONE: rxphalign_out per channel deasserts once that channel's rxphaligndone_in=1; when all N done -> MM_POLL_DMON.
REQ-013 MM_POLL_DMON (one cycle): OR of dmon_bad_align_in=0 -> DONE; else retry_count+1; if new count < P_MAX_MM_RETRIES -> MM_WAIT_DLYSRESETDONE (reassert all rxdlysreset_out), else -> AM_WAIT_DRP.
REQ-014 Entering AM_WAIT_DRP: rxphalignen_out=0, rxphalign_out=0, drp_switch_am_out=1, drp_reconfig_rdy_out=1; on DRP edge drop rdy, pulse all rxdlysreset_out one cycle, -> AM_WAIT_SYNCDONE.
REQ-015 AM_WAIT_SYNCDONE: on master rxsyncdone_in rising edge -> DONE.
REQ-016 DONE: done_out=1, error_out=0; hold until start_in, which re-runs REQ-009.
REQ-017 Timeout: counter clears on every state change, increments in states 1,2,3,5,6; reaching P_TIMEOUT_CYCLES-1 -> ERROR.
REQ-018 ERROR: error_out=1, done_out=0, all GT controls 0, drp_reconfig_rdy_out=0; exit only via start_in.
REQ-019 start_in outside IDLE/DONE/ERROR SHALL be ignored.
REQ-020 DRP edge and timeout terminal count in same cycle: DRP edge wins.
REQ-021 retry_count_out saturates at P_MAX_MM_RETRIES; no wrap.

Reset
REQ-022 On reset assertion, asynchronously: state IDLE, all outputs 0, counters 0, edge registers 0.
REQ-023 Reset mid-operation SHALL abort immediately; no output pulse on deassertion.

Verification
REQ-024 N=4, clean: start, DRP edge, all dlysresetdone, all phaligndone, dmon=0 -> done_out=1, retry_count_out=0, drp_switch_am_out=0.
REQ-025 Staggered channels: ch2 dlysresetdone 10 clocks after others -> only rxdlysreset_out[2] still high; phalign asserted only after ch2.
REQ-026 dmon_bad_align_in[1]=1 persistent, P_MAX_MM_RETRIES=3 -> three MM passes, retry_count_out=3, AM_WAIT_DRP, drp_switch_am_out=1; DRP edge + master syncdone -> done_out=1.
REQ-027 workaround_bypass_in=1 at start -> straight to state 5, no rxphalignen_out assertion.
REQ-028 P_TIMEOUT_CYCLES=32, withhold phaligndone -> ERROR after 32 clocks in state 3, error_out=1; start_in -> clean retry.
REQ-029 Reset asserted in state 2 -> all outputs 0 same cycle, sm_state_out=0.
